// File: rtl/ro_serial_pkg.sv
// Shared types and constants for the ring-oscillator frame serializer.
// Imported by the serializer top and its interface users.
package ro_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_GAP  = 3'd4
    } ser_state_e;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
    localparam int         CSUM_W        = 8;

endpackage

// File: rtl/ro_frame_serializer_if.sv
// Bus between the RO counter banks / RPi pins and the frame serializer.
// master = stimulus/counter side, slave = serializer.
interface ro_frame_serializer_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = 2
) ();
    logic [NUM_CH*CNT_W-1:0] counts;
    logic                    start;
    logic                    continuous;
    logic                    DATA_OUT;
    logic                    FRAME;
    logic [SEL_W-1:0]        C;
    logic                    busy;

    modport master (
        output counts, start, continuous,
        input  DATA_OUT, FRAME, C, busy
    );

    modport slave (
        input  counts, start, continuous,
        output DATA_OUT, FRAME, C, busy
    );
endinterface

// File: rtl/ro_piso_shift.sv
// Parallel-load, LSB-first shift register holding the frame's count snapshot.
// Load has priority over shift; dout is always the current bit 0.
module ro_piso_shift #(
    parameter int W = 8
) (
    input  logic         data_clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] shreg_r;

    // Snapshot register: load a whole frame of counts, then shift toward bit 0.
    always_ff @(posedge data_clk) begin
        if (!reset) begin
            shreg_r <= '0;
        end else if (load) begin
            shreg_r <= din;
        end else if (shift) begin
            shreg_r <= shreg_r >> 1;
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign dout = shreg_r[0];

endmodule

// File: rtl/ro_frame_serializer.sv
// Serializes an atomic snapshot of NUM_CH ring-oscillator counts as
// sync word + count bits + XOR checksum, then advances the select lines C.
module ro_frame_serializer
    import ro_serial_pkg::*;
#(
    parameter int                NUM_CH    = 8,
    parameter int                CNT_W     = 32,
    parameter int                SEL_W     = 2,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
    parameter int                GAP_CYC   = 4
) (
    input  logic                   data_clk,
    input  logic                   reset,
    ro_frame_serializer_if.slave   bus
);

    localparam int TOT_W  = NUM_CH * CNT_W;
    localparam int NBYTES = TOT_W / 8;
    localparam int MAX_A  = (CNT_W > SYNC_W) ? CNT_W : SYNC_W;
    localparam int MAX_B  = (MAX_A > CSUM_W) ? MAX_A : CSUM_W;
    localparam int MAX_C  = (MAX_B > GAP_CYC) ? MAX_B : GAP_CYC;
    localparam int BIT_W  = $clog2(MAX_C);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(SYNC_W - 1);
    localparam logic [BIT_W-1:0] CNT_LAST  = BIT_W'(CNT_W - 1);
    localparam logic [BIT_W-1:0] CSUM_LAST = BIT_W'(CSUM_W - 1);
    localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'(GAP_CYC - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    if (CNT_W % 8 != 0) begin : g_chk_cnt_w
        $error("CNT_W must be a multiple of 8");
    end
    if (NUM_CH < 1) begin : g_chk_num_ch
        $error("NUM_CH must be at least 1");
    end
    if (GAP_CYC < 1) begin : g_chk_gap
        $error("GAP_CYC must be at least 1");
    end

    function automatic logic [CSUM_W-1:0] xor_bytes(input logic [TOT_W-1:0] v);
        logic [CSUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NBYTES; i++) begin
            acc = acc ^ v[i*8 +: 8];
        end
        return acc;
    endfunction

    ser_state_e        state_r, state_nx;
    logic [BIT_W-1:0]  bit_cnt_r, bit_nx;
    logic [CH_W-1:0]   ch_cnt_r, ch_nx;
    logic [CSUM_W-1:0] csum_r;
    logic [SYNC_W-1:0] sync_sr_r;
    logic [SEL_W-1:0]  c_r;
    logic              data_out_r, frame_r, busy_r;
    logic              snap_s, shift_s, frame_s, bit_s, piso_bit_s;

    ro_piso_shift #(.W(TOT_W)) u_shadow (
        .data_clk (data_clk),
        .reset    (reset),
        .load     (snap_s),
        .shift    (shift_s),
        .din      (bus.counts),
        .dout     (piso_bit_s)
    );

    // Next-state, counter and serial-bit selection; outputs lag state by one edge.
    always_comb begin
        state_nx = state_r;
        bit_nx   = bit_cnt_r + BIT_W'(1);
        ch_nx    = ch_cnt_r;
        snap_s   = 1'b0;
        shift_s  = 1'b0;
        frame_s  = 1'b0;
        bit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bit_nx = '0;
                ch_nx  = '0;
                if (bus.start || bus.continuous) begin
                    state_nx = ST_SYNC;
                    snap_s   = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SYNC: begin
                frame_s = 1'b1;
                bit_s   = sync_sr_r[SYNC_W-1];
                if (bit_cnt_r == SYNC_LAST) begin
                    state_nx = ST_DATA;
                    bit_nx   = '0;
                    ch_nx    = '0;
                end else begin
                    state_nx = ST_SYNC;
                end
            end
            ST_DATA: begin
                frame_s = 1'b1;
                bit_s   = piso_bit_s;
                shift_s = 1'b1;
                if (bit_cnt_r == CNT_LAST) begin
                    bit_nx = '0;
                    if (ch_cnt_r == CH_LAST) begin
                        state_nx = ST_CSUM;
                        ch_nx    = '0;
                    end else begin
                        ch_nx = ch_cnt_r + CH_W'(1);
                    end
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_CSUM: begin
                frame_s = 1'b1;
                bit_s   = csum_r[bit_cnt_r[2:0]];
                if (bit_cnt_r == CSUM_LAST) begin
                    state_nx = ST_GAP;
                    bit_nx   = '0;
                    ch_nx    = '0;
                end else begin
                    state_nx = ST_CSUM;
                end
            end
            ST_GAP: begin
                if (bit_cnt_r == GAP_LAST) begin
                    bit_nx = '0;
                    ch_nx  = '0;
                    if (bus.continuous) begin
                        state_nx = ST_SYNC;
                        snap_s   = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    state_nx = ST_GAP;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                bit_nx   = '0;
                ch_nx    = '0;
            end
        endcase
    end

    // State, counters, snapshot side registers and registered outputs.
    always_ff @(posedge data_clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= '0;
            ch_cnt_r   <= '0;
            csum_r     <= '0;
            sync_sr_r  <= '0;
            c_r        <= '0;
            data_out_r <= 1'b0;
            frame_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx;
            bit_cnt_r  <= bit_nx;
            ch_cnt_r   <= ch_nx;
            data_out_r <= bit_s;
            frame_r    <= frame_s;
            busy_r     <= (state_nx != ST_IDLE);
            if (snap_s) begin
                csum_r    <= xor_bytes(bus.counts);
                sync_sr_r <= SYNC_WORD;
            end else if (state_r == ST_SYNC) begin
                csum_r    <= csum_r;
                sync_sr_r <= sync_sr_r << 1;
            end else begin
                csum_r    <= csum_r;
                sync_sr_r <= sync_sr_r;
            end
            // C steps on the same edge that drops FRAME, so it is stable across every frame.
            if (state_r == ST_GAP && bit_cnt_r == '0) begin
                c_r <= c_r + SEL_W'(1);
            end else begin
                c_r <= c_r;
            end
        end
    end

    assign bus.DATA_OUT = data_out_r;
    assign bus.FRAME    = frame_r;
    assign bus.C        = c_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_ro_frame_serializer.sv
// Directed bench for ro_frame_serializer: default build (dut_a) and a
// 2x16-bit, 3-bit-select build (dut_b), expected frames hand-computed.
module tb_ro_frame_serializer;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    ro_frame_serializer_if #(.NUM_CH(8), .CNT_W(32), .SEL_W(2)) ifa ();
    ro_frame_serializer_if #(.NUM_CH(2), .CNT_W(16), .SEL_W(3)) ifb ();

    ro_frame_serializer dut_a (
        .data_clk (clk),
        .reset    (rst_a),
        .bus      (ifa.slave)
    );

    ro_frame_serializer #(.NUM_CH(2), .CNT_W(16), .SEL_W(3)) dut_b (
        .data_clk (clk),
        .reset    (rst_b),
        .bus      (ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [271:0] got, input logic [271:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_data(input bit which);
        return which ? ifb.DATA_OUT : ifa.DATA_OUT;
    endfunction

    function automatic logic cur_frame(input bit which);
        return which ? ifb.FRAME : ifa.FRAME;
    endfunction

    function automatic int cur_c(input bit which);
        return which ? int'(ifb.C) : int'(ifa.C);
    endfunction

    function automatic int cur_busy(input bit which);
        return which ? int'(ifb.busy) : int'(ifa.busy);
    endfunction

    // Transmission order: bit k of the result is the k-th frame bit on the wire.
    function automatic logic [271:0] build_exp(input int dw, input logic [255:0] snap,
                                               input logic [7:0] csum);
        logic [271:0] v;
        v      = '0;
        v[7:0] = 8'hA5;
        for (int j = 0; j < dw; j++) v[8+j] = snap[j];
        for (int j = 0; j < 8; j++) v[8+dw+j] = csum[j];
        return v;
    endfunction

    // Pulse start for one sampling edge; returns #1 after that edge.
    task automatic start_frame(input bit which);
        if (which) ifb.start = 1'b1; else ifa.start = 1'b1;
        tick();
        if (which) ifb.start = 1'b0; else ifa.start = 1'b0;
    endtask

    // Called #1 after the snapshot edge; returns #1 after the first post-frame edge.
    task automatic capture(input bit which, input int len, input logic [271:0] exp_bits,
                           input int exp_c, input bit mutate, input string tag);
        logic [271:0] got;
        int           fcnt;
        int           c0;
        int           c_moved;
        got     = '0;
        fcnt    = 0;
        c_moved = 0;
        c0      = cur_c(which);
        for (int k = 0; k < len; k++) begin
            if (mutate && !which) begin
                for (int i = 0; i < 8; i++) ifa.counts[i*32 +: 32] = $urandom();
            end
            tick();
            if (cur_frame(which)) fcnt++;
            got[k] = cur_data(which);
            if (cur_c(which) != c0) c_moved = 1;
        end
        tick();
        check_eq({tag, "_bits"}, got, exp_bits);
        check_eq({tag, "_frame_len"}, fcnt, len);
        check_eq({tag, "_c_stable"}, c_moved, 0);
        check_eq({tag, "_frame_fall"}, {cur_frame(which), cur_data(which)}, 2'b00);
        check_eq({tag, "_c_after"}, cur_c(which), exp_c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] snap;
        int           hi;

        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.counts = '0; ifa.start = 1'b0; ifa.continuous = 1'b0;
        ifb.counts = '0; ifb.start = 1'b0; ifb.continuous = 1'b0;
        tick(); tick(); tick();
        check_eq("rst_a_outs", {ifa.DATA_OUT, ifa.FRAME, ifa.busy, ifa.C}, 5'b0);
        check_eq("rst_b_outs", {ifb.DATA_OUT, ifb.FRAME, ifb.busy, ifb.C}, 6'b0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();

        // Single frame, ch0 = 12345678, checksum 12^34^56^78 = 08
        snap = 256'h1234_5678;
        ifa.counts = snap;
        start_frame(1'b0);
        check_eq("t1_busy", ifa.busy, 1'b1);
        capture(1'b0, 272, build_exp(256, snap, 8'h08), 1, 1'b0, "t1");
        tick(); tick(); tick();
        check_eq("t1_idle", ifa.busy, 1'b0);

        // counts scrambled every cycle after the snapshot edge
        snap = '0;
        snap[31:0]  = 32'hDEAD_BEEF;
        snap[63:32] = 32'h0102_0304;
        ifa.counts = snap;
        start_frame(1'b0);
        capture(1'b0, 272, build_exp(256, snap, 8'h26), 2, 1'b1, "t2");
        tick(); tick(); tick();
        check_eq("t2_idle", ifa.busy, 1'b0);

        // start held high through the frame: one frame only
        snap = '0;
        snap[255:224] = 32'h8000_0001;
        ifa.counts = snap;
        ifa.start = 1'b1;
        tick();
        capture(1'b0, 272, build_exp(256, snap, 8'h81), 3, 1'b0, "t3");
        ifa.start = 1'b0;
        hi = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (ifa.FRAME) hi++;
        end
        check_eq("t3_no_second_frame", hi, 0);
        check_eq("t3_idle", ifa.busy, 1'b0);

        // reset to bring C back to 0, then five continuous frames
        rst_a = 1'b0;
        tick();
        check_eq("t4_rst_c", ifa.C, 2'd0);
        rst_a = 1'b1;
        snap = '0;
        snap[31:0]  = 32'hDEAD_BEEF;
        snap[63:32] = 32'h0102_0304;
        ifa.counts = snap;
        ifa.continuous = 1'b1;
        tick();
        for (int f = 0; f < 5; f++) begin
            capture(1'b0, 272, build_exp(256, snap, 8'h26), (f + 1) % 4, 1'b0, "t4_cont");
            if (f == 4) ifa.continuous = 1'b0;
            hi = 0;
            for (int g = 0; g < 3; g++) begin
                tick();
                if (ifa.FRAME || ifa.DATA_OUT) hi++;
            end
            check_eq("t4_gap_quiet", hi, 0);
        end
        check_eq("t4_idle", ifa.busy, 1'b0);

        // one more frame takes C to 2, then reset in the middle of DATA
        start_frame(1'b0);
        capture(1'b0, 272, build_exp(256, snap, 8'h26), 2, 1'b0, "t5");
        tick(); tick(); tick();
        start_frame(1'b0);
        for (int k = 0; k < 108; k++) tick();
        check_eq("t5_mid_frame", {ifa.FRAME, ifa.C}, 3'b110);
        rst_a = 1'b0;
        tick();
        check_eq("t5_rst_outs", {ifa.DATA_OUT, ifa.FRAME, ifa.busy, ifa.C}, 5'b0);
        rst_a = 1'b1;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ifa.FRAME) hi++;
        end
        check_eq("t5_no_resume", hi, 0);
        check_eq("t5_c_held", ifa.C, 2'd0);

        // small build: ch0=FFFF, ch1=00FF, checksum FF^FF^FF^00 = FF, C wraps 7->0
        ifb.counts = 32'h00FF_FFFF;
        snap = 256'h00FF_FFFF;
        for (int f = 0; f < 8; f++) begin
            start_frame(1'b1);
            capture(1'b1, 48, build_exp(32, snap, 8'hFF), (f + 1) % 8, 1'b0, "t6");
            tick(); tick(); tick();
        end
        check_eq("t6_c_wrapped", ifb.C, 3'd0);
        check_eq("t6_idle", ifb.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
